// File: rtl/mips32_prog_loader_if.sv
// Loader bus: start/stream handshake in, memory write port and
// core status out. master = host/tb side, slave = loader.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  core_hold, done, load_err, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output core_hold, done, load_err, words_loaded
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader: framed big-endian byte stream -> memory words,
// holds the core until the XOR checksum of the image matches.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   start, in_valid/in_data/in_ready stream, mem_we/mem_addr/
//   mem_wdata write port, core_hold, done, load_err, words_loaded.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int BASE_ADDR = 0
) (
  input logic                  clk,
  input logic                  rst,
  mips32_prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, WORD,
    WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       widx_q, widx_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              rdy;
  logic              xfer;
  logic [15:0]       n_w;
  logic [31:0]       end_w;

  assign rdy = (state_q == LEN_HI) || (state_q == LEN_LO) ||
               (state_q == WORD)   || (state_q == CSUM);
  assign xfer = bus.in_valid && rdy;

  // Length as it will be once LEN_LO is latched; used for
  // the overflow check in the same cycle.
  assign n_w   = {count_q[15:8], bus.in_data};
  assign end_w = 32'(BASE_ADDR) + {16'h0, n_w};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      widx_q  <= '0;
      csum_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      csum_q  <= csum_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    csum_d  = csum_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d = LEN_HI;
          count_d = '0;
          widx_d  = '0;
          csum_d  = '0;
          bidx_d  = '0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          count_d[15:8] = bus.in_data;
          csum_d = csum_q ^ bus.in_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          count_d[7:0] = bus.in_data;
          csum_d = csum_q ^ bus.in_data;
          if (end_w > 32'(MEM_DEPTH))
            state_d = ERR;
          else if (n_w == 16'h0)
            state_d = CSUM;
          else
            state_d = WORD;
        end
      end
      WORD: begin
        if (xfer) begin
          word_d = {word_q[23:0], bus.in_data};
          csum_d = csum_q ^ bus.in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // Write strobe is registered so it lines
            // up with the WRITE state cycle.
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = BASE + widx_q[ADDR_W-1:0];
            wdata_d = word_d;
          end
        end
      end
      WRITE: begin
        widx_d = widx_q + 16'd1;
        if (widx_d == count_q)
          state_d = CSUM;
        else
          state_d = WORD;
      end
      CSUM: begin
        if (xfer) begin
          if (bus.in_data == csum_q)
            state_d = DONE;
          else
            state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = rdy;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.done         = (state_q == DONE);
  assign bus.load_err     = (state_q == ERR);
  assign bus.core_hold    = (state_q != DONE);
  assign bus.words_loaded = widx_q[ADDR_W:0];

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: good/bad/empty/oversize
// loads, stream gaps and a mid-load reset.
module tb_mips32_prog_loader;

  localparam int AW = 10;

  logic clk;
  logic rst;

  mips32_prog_loader_if #(.ADDR_W(AW)) bus ();

  mips32_prog_loader #(
    .ADDR_W(AW), .MEM_DEPTH(1024), .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  logic [AW-1:0] wa_log [$];
  logic [31:0]   wd_log [$];
  logic          mon_en = 1'b0;
  int            n_nr, n_we, n_both;

  // Writes and in_ready-low cycles observed mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      wa_log.push_back(bus.mem_addr);
      wd_log.push_back(bus.mem_wdata);
    end
    if (mon_en && !bus.done && !bus.load_err) begin
      if (!bus.in_ready) n_nr++;
      if (bus.mem_we) n_we++;
      if (!bus.in_ready && bus.mem_we) n_both++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wa_log.delete();
    wd_log.delete();
    n_nr = 0;
    n_we = 0;
    n_both = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Present a byte and hold it until accepted.
  task automatic send_byte(input logic [7:0] b,
                           input int gaps);
    bit ok;
    ok = 1'b0;
    repeat (gaps) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("byte_timeout", 64'(b), 64'hFFFF);
  endtask

  task automatic send_stream(input logic [7:0] s [],
                             input bit gappy);
    foreach (s[i])
      send_byte(s[i], gappy ? $urandom_range(0, 2) : 0);
  endtask

  task automatic chk_good(input string tag);
    chk({tag, "_nwr"}, 64'(wa_log.size()), 64'd2);
    if (wa_log.size() == 2) begin
      chk({tag, "_a0"}, 64'(wa_log[0]), 64'd0);
      chk({tag, "_d0"}, 64'(wd_log[0]), 64'h2801000A);
      chk({tag, "_a1"}, 64'(wa_log[1]), 64'd1);
      chk({tag, "_d1"}, 64'(wd_log[1]), 64'hFC000000);
    end
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_hold"}, 64'(bus.core_hold), 64'd0);
    chk({tag, "_err"}, 64'(bus.load_err), 64'd0);
    chk({tag, "_wl"}, 64'(bus.words_loaded), 64'd2);
  endtask

  logic [7:0] good [] = '{8'h00, 8'h02, 8'h28, 8'h01,
                          8'h00, 8'h0A, 8'hFC, 8'h00,
                          8'h00, 8'h00, 8'hDD};
  logic [7:0] bad  [] = '{8'h00, 8'h02, 8'h28, 8'h01,
                          8'h00, 8'h0A, 8'hFC, 8'h00,
                          8'h00, 8'h00, 8'hDC};
  logic [7:0] part [] = '{8'h00, 8'h02, 8'h28, 8'h01,
                          8'h00, 8'h0A, 8'hFC, 8'h00};
  logic [7:0] empt [] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] over [] = '{8'h04, 8'h01};

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    clr_log();
    #12;
    chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wd", 64'(bus.mem_wdata), 64'd0);
    chk("rst_hold", 64'(bus.core_hold), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.load_err), 64'd0);
    chk("rst_wl", 64'(bus.words_loaded), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Good N=2 load
    clr_log();
    pulse_start();
    chk("g_rdy", 64'(bus.in_ready), 64'd1);
    chk("g_hold0", 64'(bus.core_hold), 64'd1);
    mon_en = 1'b1;
    send_stream(good, 1'b0);
    mon_en = 1'b0;
    chk_good("good");
    chk("good_nr_eq_we", 64'(n_nr), 64'(n_we));
    chk("good_we", 64'(n_we), 64'd2);

    // Bad checksum, then reload from ERR
    clr_log();
    pulse_start();
    chk("b_hold0", 64'(bus.core_hold), 64'd1);
    chk("b_done0", 64'(bus.done), 64'd0);
    send_stream(bad, 1'b0);
    chk("bad_nwr", 64'(wa_log.size()), 64'd2);
    chk("bad_err", 64'(bus.load_err), 64'd1);
    chk("bad_done", 64'(bus.done), 64'd0);
    chk("bad_hold", 64'(bus.core_hold), 64'd1);
    clr_log();
    pulse_start();
    chk("rl_err", 64'(bus.load_err), 64'd0);
    send_stream(good, 1'b0);
    chk_good("reload");

    // Empty image
    clr_log();
    pulse_start();
    send_stream(empt, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("e_nwr", 64'(wa_log.size()), 64'd0);
    chk("e_done", 64'(bus.done), 64'd1);
    chk("e_wl", 64'(bus.words_loaded), 64'd0);

    // Oversize length
    clr_log();
    pulse_start();
    send_stream(over, 1'b0);
    chk("o_err", 64'(bus.load_err), 64'd1);
    chk("o_rdy", 64'(bus.in_ready), 64'd0);
    chk("o_hold", 64'(bus.core_hold), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("o_nwr", 64'(wa_log.size()), 64'd0);

    // Backpressure: random in_valid gaps
    clr_log();
    pulse_start();
    mon_en = 1'b1;
    send_stream(good, 1'b1);
    mon_en = 1'b0;
    chk_good("bp");
    chk("bp_nr_eq_we", 64'(n_nr), 64'd2);
    chk("bp_both", 64'(n_both), 64'd2);

    // Reset between edges, mid word 1
    clr_log();
    pulse_start();
    send_stream(part, 1'b0);
    chk("m_wl1", 64'(bus.words_loaded), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("m_hold", 64'(bus.core_hold), 64'd1);
    chk("m_done", 64'(bus.done), 64'd0);
    chk("m_err", 64'(bus.load_err), 64'd0);
    chk("m_we", 64'(bus.mem_we), 64'd0);
    chk("m_wl", 64'(bus.words_loaded), 64'd0);
    chk("m_rdy", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clr_log();
    pulse_start();
    send_stream(good, 1'b0);
    chk_good("post_rst");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
